currency_accum: RTL and testbench

Multi-channel coin/note credit accumulator with a vend handshake and change return. It sits between the coin-acceptor front ends and the product-dispense controller. Each channel is synchronised and edge-detected, and at most one pending credit is serviced per cycle by fixed priority. Credit is bounded so that it never wraps, a vend is granted only when credit covers the price, and the surplus (or full credit on cancel) is returned through a change handshake.

---
 rtl/currency_pkg.sv | 27 ++
 rtl/coin_sync.sv | 39 +++
 rtl/currency_accum.sv | 186 ++++++++++++++++++
 tb/tb_currency_accum.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/currency_pkg.sv
// Shared types and constants for the coin credit accumulator: FSM state
// encoding, default widths and the channel-slice helper.
package currency_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_VALUE_W = 7;
  localparam int DEF_TOTAL_W = 10;

  // Widest packed coin bus and channel value the slice helper can handle.
  localparam int MAX_BUS_W = 256;
  localparam int MAX_VAL_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  // Channel ch's value from a packed bus of w-bit fields; callers truncate to w.
  function automatic logic [MAX_VAL_W-1:0] ch_slice(input logic [MAX_BUS_W-1:0] bus,
                                                    input int                   ch,
                                                    input int                   w);
    return MAX_VAL_W'(bus >> (ch * w));
  endfunction

endpackage

// File: rtl/coin_sync.sv
// One coin channel: 3-flop synchroniser on the asynchronous insertion level,
// rising-edge detect, and capture of the channel value on that edge.
module coin_sync #(
  parameter int VALUE_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [VALUE_W-1:0] coin_value,
  input  logic               hold,
  output logic               rise,
  output logic [VALUE_W-1:0] value
);

  logic s0;
  logic s1;
  logic s2;

  assign rise = s1 & ~s2;

  // NOTE: non-blocking assignments so each flop samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      s2    <= 1'b0;
      value <= '0;
    end else begin
      s0 <= coin_valid;
      s1 <= s0;
      s2 <= s1;
      // A coin already waiting keeps its value; the new edge is rejected upstream.
      if (rise && !hold) begin
        value <= coin_value;
      end
    end
  end

endmodule

// File: rtl/currency_accum.sv
// Multi-channel credit accumulator: per-channel pending coins serviced by
// fixed priority, saturation-safe credit, vend handshake and change return.
module currency_accum
  import currency_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int VALUE_W   = DEF_VALUE_W,
  parameter int TOTAL_W   = DEF_TOTAL_W,
  parameter int MAX_TOTAL = 2**TOTAL_W - 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         coin_valid,
  input  logic [NUM_CH*VALUE_W-1:0] coin_value,
  input  logic [TOTAL_W-1:0]        price,
  input  logic                      vend_req,
  input  logic                      cancel,
  input  logic                      dispense_ready,
  input  logic                      change_ready,
  output logic [TOTAL_W-1:0]        total_credit,
  output logic                      credit_avail,
  output logic                      dispense_valid,
  output logic                      change_valid,
  output logic [TOTAL_W-1:0]        change_amount,
  output logic [NUM_CH-1:0]         coin_reject,
  output logic                      insufficient
);

  localparam int               IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TOTAL_W:0] CEILING = (TOTAL_W + 1)'(MAX_TOTAL);

  state_t             state;
  state_t             state_nxt;
  logic [NUM_CH-1:0]  rise;
  logic [VALUE_W-1:0] ch_val [NUM_CH];
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  pend_nxt;
  logic [NUM_CH-1:0]  reject_nxt;
  logic               insuff_nxt;
  logic [TOTAL_W-1:0] total_nxt;
  logic [TOTAL_W-1:0] change_nxt;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [VALUE_W-1:0] sel_val;
  logic [TOTAL_W:0]   sum;
  logic               fits;
  logic               covers;
  logic               service_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coin_sync #(
      .VALUE_W (VALUE_W)
    ) u_sync (
      .clk        (clk),
      .rst        (rst),
      .coin_valid (coin_valid[i]),
      .coin_value (VALUE_W'(ch_slice(MAX_BUS_W'(coin_value), i, VALUE_W))),
      .hold       (pending[i]),
      .rise       (rise[i]),
      .value      (ch_val[i])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_val   = '0;
    // Scan downwards so the lowest-index pending channel wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_val   = ch_val[i];
      end
    end
  end

  // One spare bit so an overflowing sum still compares correctly against the ceiling.
  assign sum    = {1'b0, total_credit} + (TOTAL_W + 1)'(sel_val);
  assign fits   = (sum <= CEILING);
  assign covers = ({1'b0, total_credit} >= {1'b0, price});

  always_comb begin
    state_nxt  = state;
    total_nxt  = total_credit;
    change_nxt = change_amount;
    pend_nxt   = pending;
    reject_nxt = '0;
    insuff_nxt = 1'b0;
    service_ok = 1'b0;

    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i]) begin
        if (pending[i]) begin
          reject_nxt[i] = 1'b1;
        end else begin
          pend_nxt[i] = 1'b1;
        end
      end
    end

    case (state)
      ST_IDLE: begin
        service_ok = 1'b1;
      end
      ST_COLLECT: begin
        if (cancel) begin
          change_nxt = total_credit;
          state_nxt  = ST_CHANGE;
        end else if (vend_req) begin
          if (covers) begin
            change_nxt = total_credit - price;
            state_nxt  = ST_DISPENSE;
          end else begin
            insuff_nxt = 1'b1;
            service_ok = 1'b1;
          end
        end else begin
          service_ok = 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (dispense_ready) begin
          total_nxt = '0;
          state_nxt = (change_amount != '0) ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (change_ready) begin
          total_nxt  = '0;
          change_nxt = '0;
          state_nxt  = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Coins wait while a vend or refund is in flight; they are never lost there.
    if (service_ok && sel_valid) begin
      pend_nxt[sel_idx] = 1'b0;
      if (fits) begin
        total_nxt = sum[TOTAL_W-1:0];
        if (state == ST_IDLE) begin
          state_nxt = ST_COLLECT;
        end
      end else begin
        reject_nxt[sel_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // All outputs come straight from flops; valids mirror the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      total_credit   <= '0;
      change_amount  <= '0;
      credit_avail   <= 1'b0;
      dispense_valid <= 1'b0;
      change_valid   <= 1'b0;
      coin_reject    <= '0;
      insufficient   <= 1'b0;
    end else begin
      pending        <= pend_nxt;
      total_credit   <= total_nxt;
      change_amount  <= change_nxt;
      credit_avail   <= (total_nxt != '0);
      dispense_valid <= (state_nxt == ST_DISPENSE);
      change_valid   <= (state_nxt == ST_CHANGE);
      coin_reject    <= reject_nxt;
      insufficient   <= insuff_nxt;
    end
  end

endmodule

// File: tb/tb_currency_accum.sv
// Directed bench for currency_accum: a coin table applied in a loop, then
// hand-written vend, cancel, contention and reset sequences.
module tb_currency_accum;

  localparam int NUM_CH    = 4;
  localparam int VALUE_W   = 7;
  localparam int TOTAL_W   = 7;
  localparam int MAX_TOTAL = 100;

  logic                      clk;
  logic                      rst;
  logic [NUM_CH-1:0]         coin_valid;
  logic [NUM_CH*VALUE_W-1:0] coin_value;
  logic [TOTAL_W-1:0]        price;
  logic                      vend_req;
  logic                      cancel;
  logic                      dispense_ready;
  logic                      change_ready;
  logic [TOTAL_W-1:0]        total_credit;
  logic                      credit_avail;
  logic                      dispense_valid;
  logic                      change_valid;
  logic [TOTAL_W-1:0]        change_amount;
  logic [NUM_CH-1:0]         coin_reject;
  logic                      insufficient;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         ch;
    int         value;
    int         exp_total;
    logic [3:0] exp_rej;
  } coin_vec_t;

  coin_vec_t vecs [7];

  currency_accum #(
    .NUM_CH    (NUM_CH),
    .VALUE_W   (VALUE_W),
    .TOTAL_W   (TOTAL_W),
    .MAX_TOTAL (MAX_TOTAL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .price          (price),
    .vend_req       (vend_req),
    .cancel         (cancel),
    .dispense_ready (dispense_ready),
    .change_ready   (change_ready),
    .total_credit   (total_credit),
    .credit_avail   (credit_avail),
    .dispense_valid (dispense_valid),
    .change_valid   (change_valid),
    .change_amount  (change_amount),
    .coin_reject    (coin_reject),
    .insufficient   (insufficient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a value, then raise the channel; returns just after edge k+2.
  task automatic coin_in(input int ch, input int val);
    coin_value[ch*VALUE_W +: VALUE_W] = VALUE_W'(val);
    tick(2);
    coin_valid[ch] = 1'b1;
    tick(3);
  endtask

  task automatic refund(input int exp_amount);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    check("refund change_valid", 32'(change_valid), 1);
    check("refund change_amount", 32'(change_amount), exp_amount);
    change_ready = 1'b1;
    tick(1);
    change_ready = 1'b0;
    check("refund done change_valid", 32'(change_valid), 0);
    check("refund done total", 32'(total_credit), 0);
  endtask

  initial begin
    vecs[0] = '{1,  25,  25, 4'b0000};
    vecs[1] = '{3,  40,  65, 4'b0000};
    vecs[2] = '{0,  25,  90, 4'b0000};
    vecs[3] = '{2,  20,  90, 4'b0100};
    vecs[4] = '{1, 127,  90, 4'b0010};
    vecs[5] = '{0,  10, 100, 4'b0000};
    vecs[6] = '{2,   1, 100, 4'b0100};

    rst            = 1'b1;
    coin_valid     = '0;
    coin_value     = '0;
    price          = '0;
    vend_req       = 1'b0;
    cancel         = 1'b0;
    dispense_ready = 1'b0;
    change_ready   = 1'b0;
    tick(2);
    check("reset total_credit", 32'(total_credit), 0);
    check("reset credit_avail", 32'(credit_avail), 0);
    check("reset dispense_valid", 32'(dispense_valid), 0);
    check("reset change_valid", 32'(change_valid), 0);
    check("reset change_amount", 32'(change_amount), 0);
    check("reset coin_reject", 32'(coin_reject), 0);
    check("reset insufficient", 32'(insufficient), 0);
    rst = 1'b0;
    tick(1);

    // Coin table: accumulation, ceiling rejects, exact-ceiling fill.
    begin
      int prev = 0;
      for (int v = 0; v < 7; v++) begin
        coin_in(vecs[v].ch, vecs[v].value);
        check($sformatf("vec%0d total before k+3", v), 32'(total_credit), prev);
        tick(1);
        check($sformatf("vec%0d total", v), 32'(total_credit), vecs[v].exp_total);
        check($sformatf("vec%0d coin_reject", v), 32'(coin_reject), 32'(vecs[v].exp_rej));
        check($sformatf("vec%0d credit_avail", v), 32'(credit_avail), 1);
        prev = vecs[v].exp_total;
        coin_valid[vecs[v].ch] = 1'b0;
        tick(4);
      end
    end
    refund(100);

    // Single coin, vend with surplus, slow dispense acceptance.
    coin_in(1, 25);
    check("vend1 total at k+2", 32'(total_credit), 0);
    tick(1);
    check("vend1 total at k+3", 32'(total_credit), 25);
    coin_valid = '0;
    price    = 7'd20;
    vend_req = 1'b1;
    tick(1);
    vend_req = 1'b0;
    check("vend1 dispense_valid c1", 32'(dispense_valid), 1);
    check("vend1 change_amount", 32'(change_amount), 5);
    tick(1);
    check("vend1 dispense_valid c2", 32'(dispense_valid), 1);
    tick(1);
    check("vend1 dispense_valid c3", 32'(dispense_valid), 1);
    dispense_ready = 1'b1;
    tick(1);
    dispense_ready = 1'b0;
    check("vend1 dispense_valid done", 32'(dispense_valid), 0);
    check("vend1 change_valid", 32'(change_valid), 1);
    check("vend1 change_amount held", 32'(change_amount), 5);
    check("vend1 total cleared", 32'(total_credit), 0);
    change_ready = 1'b1;
    tick(1);
    change_ready = 1'b0;
    check("vend1 change_valid done", 32'(change_valid), 0);
    check("vend1 change_amount cleared", 32'(change_amount), 0);
    tick(3);

    // Three simultaneous edges serviced one per cycle, lowest index first.
    coin_value[0*VALUE_W +: VALUE_W] = 7'd10;
    coin_value[2*VALUE_W +: VALUE_W] = 7'd50;
    coin_value[3*VALUE_W +: VALUE_W] = 7'd5;
    tick(2);
    coin_valid = 4'b1101;
    tick(3);
    check("multi total at k+2", 32'(total_credit), 0);
    tick(1);
    check("multi total ch0", 32'(total_credit), 10);
    tick(1);
    check("multi total ch2", 32'(total_credit), 60);
    tick(1);
    check("multi total ch3", 32'(total_credit), 65);
    coin_valid = '0;
    tick(4);
    refund(65);

    // Insufficient credit, then cancel beating a covering vend_req.
    coin_in(2, 15);
    tick(1);
    coin_valid = '0;
    check("insuf total", 32'(total_credit), 15);
    price    = 7'd40;
    vend_req = 1'b1;
    tick(1);
    vend_req = 1'b0;
    check("insuf pulse", 32'(insufficient), 1);
    check("insuf no dispense", 32'(dispense_valid), 0);
    check("insuf total kept", 32'(total_credit), 15);
    tick(1);
    check("insuf pulse ends", 32'(insufficient), 0);
    cancel   = 1'b1;
    vend_req = 1'b1;
    price    = 7'd10;
    tick(1);
    cancel   = 1'b0;
    vend_req = 1'b0;
    check("cancel change_valid", 32'(change_valid), 1);
    check("cancel change_amount", 32'(change_amount), 15);
    check("cancel no dispense", 32'(dispense_valid), 0);
    change_ready = 1'b1;
    tick(1);
    change_ready = 1'b0;
    check("cancel done total", 32'(total_credit), 0);
    tick(3);

    // Coin arriving during DISPENSE is held, a repeat edge is rejected.
    coin_in(1, 30);
    tick(1);
    coin_valid = '0;
    price    = 7'd30;
    vend_req = 1'b1;
    tick(1);
    vend_req = 1'b0;
    check("hold dispense_valid", 32'(dispense_valid), 1);
    check("hold change_amount", 32'(change_amount), 0);
    coin_in(0, 10);
    tick(1);
    check("hold total unchanged", 32'(total_credit), 30);
    check("hold still dispensing", 32'(dispense_valid), 1);
    coin_valid[0] = 1'b0;
    tick(3);
    coin_valid[0] = 1'b1;
    tick(2);
    check("repeat edge no early reject", 32'(coin_reject), 0);
    tick(1);
    check("repeat edge reject", 32'(coin_reject), 1);
    tick(1);
    check("repeat edge reject one cycle", 32'(coin_reject), 0);
    dispense_ready = 1'b1;
    tick(1);
    dispense_ready = 1'b0;
    check("hold dispense done", 32'(dispense_valid), 0);
    check("hold no change", 32'(change_valid), 0);
    check("hold total cleared", 32'(total_credit), 0);
    tick(1);
    check("held coin credited", 32'(total_credit), 10);
    check("held coin credit_avail", 32'(credit_avail), 1);
    coin_valid = '0;
    tick(4);

    // Reset in the middle of a refund with a coin pending.
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    check("rst-seq change_valid", 32'(change_valid), 1);
    check("rst-seq change_amount", 32'(change_amount), 10);
    coin_in(3, 7);
    tick(1);
    check("rst-seq change held", 32'(change_valid), 1);
    check("rst-seq total held", 32'(total_credit), 10);
    rst        = 1'b1;
    coin_valid = '0;
    tick(1);
    rst = 1'b0;
    check("mid rst change_valid", 32'(change_valid), 0);
    check("mid rst total", 32'(total_credit), 0);
    check("mid rst change_amount", 32'(change_amount), 0);
    check("mid rst credit_avail", 32'(credit_avail), 0);
    tick(6);
    check("mid rst pending lost", 32'(total_credit), 0);
    check("mid rst stays idle", 32'(change_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
